// File: rtl/riscv_structures_pkg.sv
// Shared types and constants for the RV32I front end.
package riscv_structures;

  // Canonical RV32I NOP: addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // One fetched instruction together with the address it came from
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_pkt_t;

endpackage

// File: rtl/instr_queue.sv
// Small synchronous FIFO of fetch packets sitting between instr_mem and decode.
// The head is read combinationally from storage, so it depends only on registered state.
// A flush empties the queue on the next edge and takes priority over push/pop.
module instr_queue
  import riscv_structures::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  fetch_pkt_t wr_pkt,
  output logic       full,
  output logic       empty,
  output fetch_pkt_t head
);

  fetch_pkt_t            mem [DEPTH];
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]       count_q, count_d;

  // Next-state for pointers and occupancy; pointers wrap naturally at DEPTH
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Packet storage; contents are don't-care while the slot is not occupied
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr_q] <= wr_pkt;
  end

  // Status and head view, all from registered state
  always_comb begin
    full  = (count_q == CntW'(DEPTH));
    empty = (count_q == '0);
    head  = mem[rd_ptr_q];
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives instr_mem, and buffers fetched words
// in a prefetch queue that decode drains over a valid/ready handshake.
// A redirect flushes the queue and restarts fetch at the word-aligned target.
module fetch_unit
  import riscv_structures::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr
);

  logic [31:0] pc_q, pc_d;
  logic        push, pop;
  logic        q_full, q_empty;
  fetch_pkt_t  wr_pkt, head;

  // Handshake policy: redirect suppresses both sides; a pop frees a slot for a same-cycle push
  always_comb begin
    pop    = !q_empty && out_ready && !redirect_valid;
    push   = !redirect_valid && (!q_full || pop);
    wr_pkt = '{pc: pc_q, instr: imem_data};
  end

  // Next PC: redirect target (word aligned) wins, else advance on every captured word
  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = redirect_pc & 32'hFFFF_FFFC;
    end else if (push) begin
      pc_d = pc_q + 32'd4;
    end
  end

  // PC register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  instr_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (push),
    .pop    (pop),
    .flush  (redirect_valid),
    .wr_pkt (wr_pkt),
    .full   (q_full),
    .empty  (q_empty),
    .head   (head)
  );

  // Outputs come only from registered PC and queue state
  always_comb begin
    imem_addr = pc_q;
    out_valid = !q_empty;
    out_pc    = q_empty ? 32'h0 : head.pc;
    out_instr = q_empty ? NOP_INSTR : head.instr;
  end

`ifdef FETCH_DEBUG
  // Per-cycle trace of fetch progress
  always_ff @(posedge clk) begin
    if (rst_n) begin
      $display("[fetch] pc=%h push=%0b pop=%0b count=%0d redirect=%0b",
               pc_q, push, pop, u_queue.count_q, redirect_valid);
    end
  end
`endif

endmodule
